fft_frame_host: RTL and testbench
=================================

# fft_frame_host

Host-side controller for the 32-point `fft` core: the synthesizable counterpart of the bench that feeds the core. It accepts real input samples on a valid/ready stream and buffers a full frame. It then bursts the frame into the core with contiguous `load` cycles, pulses `start`, captures the N complex result words while `done` is high, and replays them on a valid/ready output stream with backpressure. It sits between the sample source (ADC/DMA front end) and the spectrum consumer, and instantiates nothing but its own buffers.

## Interface

- `WIDTH`, 16, sample/component width in bits.
- `N_2`, 5, log2 of frame length; N = 2**N_2.
- `TIMEOUT`, 1024, max cycles from `fft_start` to first `fft_done` before abort.

- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `s_valid`  in  1  input sample valid.
- `s_ready`  out  1  controller accepts input sample.
- `s_data`  in  WIDTH  signed real sample.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts output word.
- `m_data`  out  2*WIDTH  {re[2W-1:W], im[W-1:0]}, signed.
- `m_last`  out  1  marks word N-1 of the frame.
- `fft_reset`  out  1  active-high reset to the core.
- `fft_load`  out  1  core load strobe.
- `fft_rd`  out  WIDTH  core sample input.
- `fft_start`  out  1  core start strobe.
- `fft_wd`  in  2*WIDTH  core result word.
- `fft_done`  in  1  core result-valid level.
- `timeout`  out  1  one-cycle pulse on an aborted frame.
- `busy`  out  1  high in any state other than FILL.

## Operation

States: FILL → LOAD → START → WAIT → CAPTURE → DRAIN → FILL. One frame is in flight at a time. There is no overlap.

- **FILL:** `s_ready`=1. Each `s_valid && s_ready` writes `s_data` to `in_buf[cnt]` and increments `cnt`. The accept at cnt=N-1 moves the block to LOAD and clears `cnt`.
- **LOAD:** N consecutive cycles with `fft_load`=1 and `fft_rd`=`in_buf[k]`, for k=0..N-1 in order.
  - `fft_load` and `fft_rd` are registered and aligned in the same cycle.
  - There are no gaps.
- **START:** exactly one cycle with `fft_start`=1. In that cycle `fft_load`=0 and `fft_rd`=0.
- **WAIT:** the timeout counter counts from 0.
  - The first cycle with `fft_done`=1 enters CAPTURE and captures word 0 in that same cycle.
  - If the count reaches TIMEOUT-1 without `fft_done`, the block pulses `timeout`, asserts `fft_reset` for one cycle, and returns to FILL. The frame is discarded.
- **CAPTURE:** every cycle with `fft_done`=1 writes `fft_wd` to `out_buf[cnt]` and increments `cnt`.
  - Cycles with `fft_done`=0 are skipped and do not advance `cnt`.
  - After word N-1 the block enters DRAIN.
  - `fft_done` staying high after word N-1 is ignored.
- **DRAIN:** `m_valid`=1, `m_data`=`out_buf[k]`, and `m_last`=(k==N-1).
  - k advances on `m_valid && m_ready`.
  - `m_data` and `m_last` hold stable while `m_ready`=0.
  - The handshake on the last word returns the block to FILL.
- **Data path:** the block passes data through with no arithmetic. Output word order is the core's output order.

## Timing

- **Reset** (`reset`=0 at a clk edge):
  - State goes to FILL and every counter clears.
  - Buffer contents are not cleared.
  - In every cycle where `reset`=0: `s_ready`, `m_valid`, `m_last`, `fft_load`, `fft_start`, `timeout` and `busy` are 0; `fft_rd` and `m_data` are 0; `fft_reset` is 1.
- **Reset mid-frame:** the partial frame is dropped, with no `m_last`. The first accepted sample after release becomes word 0 of a new frame.
- **`s_ready`:** equals (state==FILL) && `reset`.
- **Minimum latency:** from the last input accept to the first `m_valid` is N (LOAD) + 1 (START) + core latency + N (CAPTURE) cycles.
- **Simultaneous events:**
  - At the last DRAIN handshake, `s_ready` rises the next cycle. The same-cycle input is not accepted.
  - `fft_done`=1 in the START cycle is ignored. Capture begins only in WAIT.

## Structure

- **Shared package (`fft_pkg`):**
  - `cplx_t` packed struct {re, im}, each `logic signed [WIDTH-1:0]`.
  - State enum `host_state_t`.
  - Constant `N = 1<<N_2`.
- **Sub-module `fft_frame_buf`:** simple dual-port buffer (1 write, 1 read port, registered read), instantiated twice.
  - `in_buf`: N × WIDTH.
  - `out_buf`: N × 2·WIDTH.
  - The registered read requires a one-cycle prefetch in LOAD and DRAIN.

## Test plan

- **Ramp frame:** stream `s_data`=0..31 with `s_valid` always high. Check 32 consecutive `fft_load` cycles with `fft_rd`=0..31, then a single `fft_start` cycle with `fft_load`=0.
- **Input gaps:** toggle `s_valid` randomly, 50% duty. The load burst is still 32 contiguous cycles and holds identical data.
- **Output order:** use a core model returning `fft_wd`={k, ~k} on the k-th `fft_done` cycle, with `done` dropped for 3 cycles at k=10. `m_data` sequence is {k, ~k} for k=0..31, and `m_last` is high only at k=31.
- **Backpressure:** hold `m_ready`=0 for 5 cycles at word 7. `m_data`={7, ~7} stays stable throughout, with no skipped or duplicated words.
- **Timeout:** the core model never asserts `done`. Exactly TIMEOUT cycles after `fft_start`, `timeout` and `fft_reset` pulse for one cycle, then `s_ready`=1 the next cycle.
- **Reset mid-frame:** pull `reset` low during DRAIN word 12. All outputs go to reset values and `fft_reset`=1. After release, a fresh 32-sample frame completes normally.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg
// Types and constants shared by the 32-point FFT host controller and the
// code around it.
//   FFT_WIDTH    : default sample / component width in bits
//   FFT_N_2      : default log2 of the frame length
//   N            : default frame length (1 << FFT_N_2)
//   cplx_t       : packed complex word {re, im}, re in the upper half
//   host_state_t : frame controller state encoding
package fft_pkg;

  localparam int FFT_WIDTH = 16;
  localparam int FFT_N_2   = 5;
  localparam int N         = 1 << FFT_N_2;

  typedef struct packed {
    logic signed [FFT_WIDTH-1:0] re;
    logic signed [FFT_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic [2:0] {
    S_FILL,
    S_LOAD,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_DRAIN
  } host_state_t;

endpackage

// File: rtl/fft_frame_buf.sv
// fft_frame_buf
// Simple dual-port frame buffer: one write port and one read port with a
// registered read. Read data appears the cycle after rd_en is sampled and
// holds while rd_en is low. A same-address read and write returns the old word.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read enable (updates rd_data)
//   rd_addr : read address
//   rd_data : registered read data
module fft_frame_buf #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_frame_host.sv
// fft_frame_host
// Host-side controller for the FFT core. It buffers one frame of real
// samples from a valid/ready stream, bursts the frame into the core, pulses
// start, and captures the N result words while fft_done is high. It then
// replays them on a valid/ready output stream. One frame is in flight at a time.
//   clk, reset                 : clock, synchronous active-low reset
//   s_valid/s_ready/s_data     : input sample stream
//   m_valid/m_ready/m_data     : output stream, m_data = {re, im}
//   m_last                     : marks word N-1
//   fft_reset                  : active-high reset to the core
//   fft_load/fft_rd            : core load strobe and sample
//   fft_start                  : core start strobe
//   fft_wd/fft_done            : core result word and result-valid level
//   timeout                    : one-cycle pulse when a frame is aborted
//   busy                       : high outside FILL
module fft_frame_host
  import fft_pkg::*;
#(
  parameter int WIDTH   = FFT_WIDTH,
  parameter int N_2     = FFT_N_2,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [2*WIDTH-1:0] m_data,
  output logic               m_last,
  output logic               fft_reset,
  output logic               fft_load,
  output logic [WIDTH-1:0]   fft_rd,
  output logic               fft_start,
  input  logic [2*WIDTH-1:0] fft_wd,
  input  logic               fft_done,
  output logic               timeout,
  output logic               busy
);

  localparam int NF = 1 << N_2;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [N_2-1:0] LAST_IDX = N_2'(NF - 1);
  localparam logic [N_2-1:0] PEN_IDX  = N_2'(NF - 2);
  // The abort pulse is armed one count early so the registered pulse lines
  // up with the cycle in which the count reads TIMEOUT-1.
  localparam logic [TW-1:0]  TO_ARM   = TW'(TIMEOUT - 2);

  host_state_t        state;
  logic [N_2-1:0]     cnt;
  logic [TW-1:0]      tcnt;
  logic               load_reg;
  logic               start_reg;
  logic               valid_reg;
  logic               last_reg;
  logic               timeout_reg;
  logic               fft_reset_reg;

  logic               s_fire;
  logic               m_fire;
  logic               out_wr;
  logic               out_rd_en;
  logic [N_2-1:0]     in_rd_addr;
  logic [N_2-1:0]     out_rd_addr;
  logic [WIDTH-1:0]   in_rd_data;
  logic [2*WIDTH-1:0] out_rd_data;

  assign s_ready = (state == S_FILL) && reset;
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = valid_reg && m_ready;

  // A result word is stored on any done cycle in CAPTURE, and on the first
  // done cycle in WAIT unless that frame is already being aborted.
  assign out_wr = reset && fft_done &&
                  (((state == S_WAIT) && !timeout_reg) || (state == S_CAPTURE));

  // Prefetch: outside LOAD the read port sits on word 0, so word 0 is
  // already in the read register on the first LOAD cycle. Inside LOAD it
  // runs one address ahead of cnt.
  assign in_rd_addr  = (state == S_LOAD) ? cnt + 1'b1 : '0;
  assign out_rd_addr = (state == S_DRAIN) ? cnt + 1'b1 : '0;
  // The output read register freezes while the consumer stalls, so m_data holds.
  assign out_rd_en   = (state != S_DRAIN) || m_fire;

  fft_frame_buf #(.ADDR_W(N_2), .DATA_W(WIDTH)) in_buf (
    .clk     (clk),
    .wr_en   (s_fire),
    .wr_addr (cnt),
    .wr_data (s_data),
    .rd_en   (1'b1),
    .rd_addr (in_rd_addr),
    .rd_data (in_rd_data)
  );

  fft_frame_buf #(.ADDR_W(N_2), .DATA_W(2*WIDTH)) out_buf (
    .clk     (clk),
    .wr_en   (out_wr),
    .wr_addr (cnt),
    .wr_data (fft_wd),
    .rd_en   (out_rd_en),
    .rd_addr (out_rd_addr),
    .rd_data (out_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_FILL;
      cnt           <= '0;
      tcnt          <= '0;
      load_reg      <= 1'b0;
      start_reg     <= 1'b0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      fft_reset_reg <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          if (s_fire) begin
            if (cnt == LAST_IDX) begin
              state    <= S_LOAD;
              cnt      <= '0;
              load_reg <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (cnt == LAST_IDX) begin
            state     <= S_START;
            cnt       <= '0;
            load_reg  <= 1'b0;
            start_reg <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_START: begin
          state     <= S_WAIT;
          start_reg <= 1'b0;
          tcnt      <= '0;
        end
        S_WAIT: begin
          if (timeout_reg) begin
            state         <= S_FILL;
            timeout_reg   <= 1'b0;
            fft_reset_reg <= 1'b0;
          end else if (fft_done) begin
            state <= S_CAPTURE;
            cnt   <= N_2'(1);
          end else begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TO_ARM) begin
              timeout_reg   <= 1'b1;
              fft_reset_reg <= 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          if (fft_done) begin
            if (cnt == LAST_IDX) begin
              state     <= S_DRAIN;
              cnt       <= '0;
              valid_reg <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (m_fire) begin
            if (cnt == LAST_IDX) begin
              state     <= S_FILL;
              cnt       <= '0;
              valid_reg <= 1'b0;
              last_reg  <= 1'b0;
            end else begin
              cnt      <= cnt + 1'b1;
              last_reg <= (cnt == PEN_IDX);
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  // Every output is forced to its reset value in any cycle where reset is low.
  assign fft_load  = load_reg && reset;
  assign fft_rd    = (load_reg && reset) ? in_rd_data : '0;
  assign fft_start = start_reg && reset;
  assign m_valid   = valid_reg && reset;
  assign m_data    = (valid_reg && reset) ? out_rd_data : '0;
  assign m_last    = last_reg && reset;
  assign timeout   = timeout_reg && reset;
  assign fft_reset = fft_reset_reg || !reset;
  assign busy      = (state != S_FILL) && reset;

endmodule

// File: tb/tb_fft_frame_host.sv
`timescale 1ns/1ps
module tb_fft_frame_host;
  import fft_pkg::*;

  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        fft_reset;
  logic        fft_load;
  logic [15:0] fft_rd;
  logic        fft_start;
  logic [31:0] fft_wd;
  logic        fft_done;
  logic        timeout;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fft_frame_host #(.WIDTH(16), .N_2(5), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .fft_reset (fft_reset),
    .fft_load  (fft_load),
    .fft_rd    (fft_rd),
    .fft_start (fft_start),
    .fft_wd    (fft_wd),
    .fft_done  (fft_done),
    .timeout   (timeout),
    .busy      (busy)
  );

  // Core model result word for the k-th done cycle: {k, ~k}
  function automatic logic [31:0] mk(input int k);
    cplx_t w;
    w.re = 16'(k);
    w.im = ~16'(k);
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic send_frame(input int base, input bit gaps);
    int   i   = 0;
    int   cyc = 0;
    logic v;
    while (i < N && cyc < 500) begin
      @(negedge clk);
      cyc++;
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = v;
      s_data  = 16'(base + i);
      if (v && s_ready) i++;
    end
    check("frame_accepted", i, N);
  endtask

  // Checks the contiguous load burst and the start cycle; leaves the bench
  // at the negedge of the start cycle with fft_done driven high (to be ignored).
  task automatic check_burst(input int base);
    int cyc = 0;
    @(negedge clk);
    s_valid = 1'b0;
    while (!fft_load && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    for (int k = 0; k < N; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("load_strobe[%0d]", k), fft_load, 1);
      check($sformatf("load_data[%0d]", k), fft_rd, 16'(base + k));
    end
    @(negedge clk);
    check("start_strobe", fft_start, 1);
    check("start_load", fft_load, 0);
    check("start_rd", fft_rd, 0);
    check("busy_start", busy, 1);
    fft_done = 1'b1;
    fft_wd   = 32'hDEADBEEF;
  endtask

  task automatic run_core(input int lat, input int drop_at, input int drop_len);
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      fft_done = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      if (k == drop_at) begin
        for (int d = 0; d < drop_len; d++) begin
          @(negedge clk);
          fft_done = 1'b0;
          fft_wd   = 32'hBAD0BAD0;
        end
      end
      @(negedge clk);
      fft_done = 1'b1;
      fft_wd   = mk(k);
    end
    @(negedge clk);
    fft_done = 1'b1;
    fft_wd   = 32'h5A5A5A5A;
    @(negedge clk);
    fft_done = 1'b0;
  endtask

  task automatic drain(input int stall_at, input int stall_len, input int abort_at);
    int k       = 0;
    int cyc     = 0;
    int stalled = 0;
    s_valid = 1'b1;
    s_data  = 16'h7777;
    while (k < N && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (m_valid) begin
        check($sformatf("m_data[%0d]", k), m_data, mk(k));
        check($sformatf("m_last[%0d]", k), m_last, 32'(k == N - 1));
        if (k == abort_at) begin
          m_ready = 1'b0;
          s_valid = 1'b0;
          reset   = 1'b0;
          return;
        end
        if (k == stall_at && stalled < stall_len) begin
          m_ready = 1'b0;
          stalled++;
        end else begin
          m_ready = 1'b1;
          k++;
        end
      end else begin
        m_ready = 1'b0;
      end
    end
    check("drain_words", k, N);
    @(negedge clk);
    check("ready_after_drain", s_ready, 1);
    check("valid_after_drain", m_valid, 0);
    check("last_after_drain", m_last, 0);
    check("busy_after_drain", busy, 0);
    s_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    int tpos;
    int resets;

    reset    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b0;
    fft_wd   = '0;
    fft_done = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_fft_load", fft_load, 0);
    check("rst_fft_start", fft_start, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_fft_rd", fft_rd, 0);
    check("rst_m_data", m_data, 0);
    check("rst_fft_reset", fft_reset, 1);
    reset = 1'b1;
    @(negedge clk);
    check("idle_s_ready", s_ready, 1);
    check("idle_fft_reset", fft_reset, 0);
    check("idle_busy", busy, 0);

    // Ramp frame, zero core latency, done high in START ignored
    send_frame(0, 1'b0);
    check_burst(0);
    run_core(0, -1, 0);
    drain(-1, 0, -1);

    // Input gaps, done dropped at word 10, backpressure at word 7
    send_frame(100, 1'b1);
    check_burst(100);
    run_core(3, 10, 3);
    drain(7, 5, -1);

    // Timeout: core never raises done
    send_frame(200, 1'b0);
    check_burst(200);
    fft_done = 1'b0;
    pulses = 0;
    tpos   = -1;
    resets = 0;
    for (int j = 1; j <= TO + 1; j++) begin
      @(negedge clk);
      if (j <= TO) begin
        if (timeout) begin
          pulses++;
          tpos = j;
        end
        if (fft_reset) resets++;
        if (j == TO) check("timeout_fft_reset", fft_reset, 1);
      end else begin
        check("ready_after_timeout", s_ready, 1);
        check("timeout_cleared", timeout, 0);
      end
    end
    check("timeout_pulses", pulses, 1);
    check("timeout_pos", tpos, TO);
    check("fft_reset_pulses", resets, 1);

    // Reset during DRAIN at word 12
    send_frame(300, 1'b0);
    check_burst(300);
    run_core(1, -1, 0);
    drain(-1, 0, 12);
    @(negedge clk);
    check("mid_s_ready", s_ready, 0);
    check("mid_m_valid", m_valid, 0);
    check("mid_m_last", m_last, 0);
    check("mid_fft_load", fft_load, 0);
    check("mid_fft_start", fft_start, 0);
    check("mid_timeout", timeout, 0);
    check("mid_busy", busy, 0);
    check("mid_fft_rd", fft_rd, 0);
    check("mid_m_data", m_data, 0);
    check("mid_fft_reset", fft_reset, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1);
    check("post_rst_busy", busy, 0);

    // Fresh frame after reset completes normally
    send_frame(400, 1'b1);
    check_burst(400);
    run_core(2, 10, 3);
    drain(-1, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
